// File: rtl/serial_adder_pkg.sv
// Shared types and encodings for the digit-serial adder/accumulator.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] MODE_ADD     = 2'b00;
    localparam logic [1:0] MODE_SUB     = 2'b01;
    localparam logic [1:0] MODE_ACC_ADD = 2'b10;
    localparam logic [1:0] MODE_ACC_SUB = 2'b11;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; DIGIT of these form the per-cycle ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_accum.sv
// Digit-serial add/subtract/accumulate unit, LSB first, DIGIT bits per clock,
// with valid/ready handshakes on operands and results.
module serial_adder_accum
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mode,
    input  logic             cin,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : gen_bad_params
        $error("serial_adder_accum: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, part_q, part_d;
    logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;

    logic [DIGIT:0]         chain;
    logic [DIGIT-1:0]       sum_dig;
    logic [WIDTH+DIGIT-1:0] part_cat;
    logic [WIDTH-1:0]       acc_src;

    assign chain[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : gen_chain
        full_adder_cell u_fa (
            .a    (x_q[i]),
            .b    (y_q[i]),
            .cin  (chain[i]),
            .sum  (sum_dig[i]),
            .cout (chain[i+1])
        );
    end

    // New digit enters at the top; after N shifts the word is LSB-aligned.
    assign part_cat = {sum_dig, part_q};
    // A same-cycle clear must be seen by the operation being accepted.
    assign acc_src  = acc_clr ? '0 : acc_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        part_d   = part_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;

        unique case (state_q)
            StIdle: begin
                if (acc_clr) acc_d = '0;
                if (in_valid) begin
                    mode_d  = mode;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = StRun;
                    unique case (mode)
                        MODE_ADD:     begin x_d = op_a;    y_d = op_b;  carry_d = cin;  end
                        MODE_SUB:     begin x_d = op_a;    y_d = ~op_b; carry_d = 1'b1; end
                        MODE_ACC_ADD: begin x_d = acc_src; y_d = op_a;  carry_d = 1'b0; end
                        MODE_ACC_SUB: begin x_d = acc_src; y_d = ~op_a; carry_d = 1'b1; end
                    endcase
                end
            end
            StRun: begin
                x_d     = x_q >> DIGIT;
                y_d     = y_q >> DIGIT;
                carry_d = chain[DIGIT];
                part_d  = part_cat[WIDTH+DIGIT-1:DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    // Top cell of the last digit is the MSB: its carry-in vs carry-out.
                    result_d = part_d;
                    cout_d   = chain[DIGIT];
                    ovf_d    = chain[DIGIT] ^ chain[DIGIT-1];
                    if (mode_q[1]) acc_d = part_d;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            part_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= MODE_ADD;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            part_q   <= part_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_accum.sv
// Directed bench: 8-bit/1-digit and 16-bit/4-digit instances of serial_adder_accum.
module tb_serial_adder_accum;
    import serial_adder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit, 1 bit per cycle
    logic       in_valid = 0, in_ready, out_valid, out_ready = 0, acc_clr = 0, cin = 0;
    logic       cout, ovf, busy;
    logic [7:0] op_a = 0, op_b = 0, result;
    logic [1:0] mode = MODE_ADD;

    // 16-bit, 4 bits per cycle
    logic        in_valid16 = 0, in_ready16, out_valid16, out_ready16 = 0, cin16 = 0;
    logic        cout16, ovf16, busy16;
    logic [15:0] op_a16 = 0, op_b16 = 0, result16;
    logic [1:0]  mode16 = MODE_ADD;

    serial_adder_accum #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a),
        .op_b(op_b), .mode(mode), .cin(cin), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cout(cout), .ovf(ovf), .busy(busy)
    );

    serial_adder_accum #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op_a(op_a16),
        .op_b(op_b16), .mode(mode16), .cin(cin16), .acc_clr(1'b0), .out_valid(out_valid16),
        .out_ready(out_ready16), .result(result16), .cout(cout16), .ovf(ovf16), .busy(busy16)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] m;
        logic [7:0] a, b;
        logic       ci;
        logic [7:0] res;
        logic       co, ov;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // All tasks are entered and left at a falling edge.
    task automatic start8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic clr);
        int w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        chk("in_ready_before_op", in_ready, 1);
        mode = m; op_a = a; op_b = b; cin = ci; acc_clr = clr; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; acc_clr = 0;
        op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    endtask

    task automatic finish8();
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        chk("in_ready_after_handshake", in_ready, 1);
    endtask

    task automatic op8(input string nm, input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic clr,
                       input logic [7:0] er, input logic eco, input logic eov);
        int lat;
        start8(m, a, b, ci, clr);
        wait8(lat);
        chk({nm, "_latency"}, lat, 8);
        chk({nm, "_result"}, result, er);
        chk({nm, "_cout"}, cout, eco);
        chk({nm, "_ovf"}, ovf, eov);
        finish8();
    endtask

    task automatic op16(input string nm, input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] b, input logic ci,
                        input logic [15:0] er, input logic eco, input logic eov);
        int lat = 0;
        mode16 = m; op_a16 = a; op_b16 = b; cin16 = ci; in_valid16 = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 0;
        while (!out_valid16 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_result"}, result16, er);
        chk({nm, "_cout"}, cout16, eco);
        chk({nm, "_ovf"}, ovf16, eov);
        out_ready16 = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready16 = 0;
        chk({nm, "_in_ready_after"}, in_ready16, 1);
    endtask

    initial begin
        int lat;
        vecs[0] = '{MODE_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{MODE_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[2] = '{MODE_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{MODE_ADD, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{MODE_ADD, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{MODE_SUB, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{MODE_ADD, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[7] = '{MODE_SUB, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};

        // Reset state while reset is held
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            op8($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0,
                vecs[i].res, vecs[i].co, vecs[i].ov);
        end

        // Accumulator: op_b must be ignored in ACC modes
        op8("acc_pre", MODE_ACC_ADD, 8'h22, 8'hAA, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        acc_clr = 1;
        @(posedge clk);
        @(negedge clk);
        acc_clr = 0;
        op8("acc_add1", MODE_ACC_ADD, 8'h10, 8'h99, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        op8("acc_add2", MODE_ACC_ADD, 8'h10, 8'h55, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0);
        op8("acc_add3", MODE_ACC_ADD, 8'h10, 8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        op8("acc_sub", MODE_ACC_SUB, 8'h31, 8'h77, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        op8("acc_wrap", MODE_ACC_ADD, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("acc_add7", MODE_ACC_ADD, 8'h07, 8'h00, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
        op8("acc_clr_with_op", MODE_ACC_ADD, 8'h05, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0);

        // Back-pressure in DONE with a stray in_valid pulse
        start8(MODE_ADD, 8'h11, 8'h22, 1'b0, 1'b0);
        wait8(lat);
        chk("hold_latency", lat, 8);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_result", k), result, 8'h33);
            chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
            chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
            in_valid = (k == 2);
            mode = MODE_ADD; op_a = 8'h01; op_b = 8'h01;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 0;
        finish8();
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_result_held", result, 8'h33);
        @(posedge clk);
        @(negedge clk);
        chk("stray_not_queued", busy, 0);

        // Reset at digit 3 of a run; acc (0x05) must also be cleared
        start8(MODE_ADD, 8'h55, 8'h11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_run_busy", busy, 1);
        rst = 1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("post_rst_in_ready", in_ready, 1);
        op8("post_rst_acc", MODE_ACC_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        op8("post_rst_add", MODE_ADD, 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

        // Wide instance, four bits per cycle
        op16("w16_wrap", MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("w16_sub_ovf", MODE_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        op16("w16_add_cin", MODE_ADD, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
